// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one 8-bit data / 10-bit address memory bus
// between N_CORES cores, one single-beat transaction at a time, with a stall watchdog.
module bus_arbiter #(
  parameter int  N_CORES = 4,
  parameter int  TIMEOUT = 16,
  localparam int OWNER_W = $clog2(N_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CORES-1:0]   grant_request,
  input  logic [N_CORES-1:0]   rw,
  input  logic [N_CORES*10-1:0] address,
  input  logic [N_CORES*8-1:0] data_from_core,
  output logic [N_CORES-1:0]   grant_given,
  output logic [7:0]           data_to_core,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [9:0]           mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ready,
  output logic [OWNER_W-1:0]   owner,
  output logic                 busy,
  output logic                 bus_error
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  logic [OWNER_W-1:0] rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [OWNER_W-1:0] winner;
  logic               req_any;
  logic [OWNER_W-1:0] cand;
  logic               timeout_hit;

  // Scan upward from the core after the last winner, wrapping at N_CORES-1.
  always_comb begin
    req_any = 1'b0;
    winner  = '0;
    cand    = rr_ptr;
    for (int i = 0; i < N_CORES; i++) begin
      cand = (cand == OWNER_W'(N_CORES - 1)) ? '0 : cand + OWNER_W'(1);
      if (!req_any && grant_request[cand]) begin
        req_any = 1'b1;
        winner  = cand;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= OWNER_W'(N_CORES - 1);
      cnt          <= '0;
      owner        <= '0;
      grant_given  <= '0;
      data_to_core <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            owner     <= winner;
            rr_ptr    <= winner;
            mem_addr  <= address[10*winner +: 10];
            mem_we    <= rw[winner];
            mem_wdata <= data_from_core[8*winner +: 8];
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // A completing memory wins over a watchdog expiry in the same cycle.
          if (mem_ready) begin
            if (!mem_we) data_to_core <= mem_rdata;
            grant_given <= N_CORES'(1) << owner;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            state       <= DONE;
          end else if (timeout_hit) begin
            data_to_core <= 8'hFF;
            grant_given  <= N_CORES'(1) << owner;
            bus_error    <= 1'b1;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          grant_given <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one default instance plus a TIMEOUT=4 instance
// for the watchdog abort, both fed from the same memory-side stimulus.
module tb_bus_arbiter;
  localparam int N = 4;
  localparam logic [3:0] EXP_RR [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   grant_request, wd_request, rw;
  logic [N*10-1:0] address;
  logic [N*8-1:0] data_from_core;
  logic [7:0]     mem_rdata;
  logic           mem_ready;

  logic [N-1:0] grant_given, wd_grant_given;
  logic [7:0]   data_to_core, wd_data_to_core;
  logic         mem_en, mem_we, wd_mem_en, wd_mem_we;
  logic [9:0]   mem_addr, wd_mem_addr;
  logic [7:0]   mem_wdata, wd_mem_wdata;
  logic [1:0]   owner, wd_owner;
  logic         busy, bus_error, wd_busy, wd_bus_error;

  bus_arbiter #(.N_CORES(N), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .grant_request(grant_request), .rw(rw),
    .address(address), .data_from_core(data_from_core),
    .grant_given(grant_given), .data_to_core(data_to_core),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .owner(owner), .busy(busy), .bus_error(bus_error)
  );

  bus_arbiter #(.N_CORES(N), .TIMEOUT(4)) dut_wd (
    .clk(clk), .reset(reset), .grant_request(wd_request), .rw(rw),
    .address(address), .data_from_core(data_from_core),
    .grant_given(wd_grant_given), .data_to_core(wd_data_to_core),
    .mem_en(wd_mem_en), .mem_we(wd_mem_we), .mem_addr(wd_mem_addr), .mem_wdata(wd_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .owner(wd_owner), .busy(wd_busy), .bus_error(wd_bus_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic w, input logic [9:0] a, input logic [7:0] d);
    rw[i]                  = w;
    address[10*i +: 10]    = a;
    data_from_core[8*i +: 8] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int got_n;
    int last_cyc;
    reset          = 1'b0;
    grant_request  = '0;
    wd_request     = '0;
    rw             = '0;
    address        = '0;
    data_from_core = '0;
    mem_rdata      = '0;
    mem_ready      = 1'b0;

    // Reset state
    tick(); tick();
    check_eq("rst_grant", grant_given, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bus_error", bus_error, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_data", data_to_core, 0);
    reset = 1'b1;
    tick();

    // Single read: core 1 reads 0x005, memory returns 0x3C
    set_core(1, 1'b0, 10'h005, 8'h00);
    grant_request = 4'b0010;
    tick();
    grant_request = 4'b0000;
    check_eq("rd_mem_en", mem_en, 1);
    check_eq("rd_mem_addr", mem_addr, 10'h005);
    check_eq("rd_mem_we", mem_we, 0);
    check_eq("rd_owner", owner, 1);
    check_eq("rd_busy", busy, 1);
    mem_ready = 1'b1;
    mem_rdata = 8'h3C;
    tick();
    mem_ready = 1'b0;
    check_eq("rd_grant", grant_given, 4'b0010);
    check_eq("rd_data", data_to_core, 8'h3C);
    check_eq("rd_mem_en_off", mem_en, 0);
    tick();
    check_eq("rd_grant_off", grant_given, 0);
    check_eq("rd_busy_off", busy, 0);

    // Single write: core 2 writes 0xA5 to 0x3FF; inputs change after the grant decision
    set_core(2, 1'b1, 10'h3FF, 8'hA5);
    grant_request = 4'b0100;
    tick();
    grant_request = 4'b0000;
    check_eq("wr_mem_we", mem_we, 1);
    check_eq("wr_mem_wdata", mem_wdata, 8'hA5);
    check_eq("wr_mem_addr", mem_addr, 10'h3FF);
    set_core(2, 1'b0, 10'h000, 8'h00);
    tick();
    check_eq("wr_hold_addr", mem_addr, 10'h3FF);
    check_eq("wr_hold_wdata", mem_wdata, 8'hA5);
    check_eq("wr_hold_we", mem_we, 1);
    check_eq("wr_hold_en", mem_en, 1);
    mem_ready = 1'b1;
    mem_rdata = 8'h99;
    tick();
    mem_ready = 1'b0;
    check_eq("wr_grant", grant_given, 4'b0100);
    check_eq("wr_data_kept", data_to_core, 8'h3C);
    tick();
    check_eq("wr_grant_off", grant_given, 0);

    // Wait states: core 3 reads 0x2AB, mem_ready low for 5 cycles
    set_core(3, 1'b0, 10'h2AB, 8'h00);
    grant_request = 4'b1000;
    tick();
    grant_request = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("ws_en%0d", k), mem_en, 1);
      check_eq($sformatf("ws_addr%0d", k), mem_addr, 10'h2AB);
      check_eq($sformatf("ws_grant%0d", k), grant_given, 0);
      tick();
    end
    check_eq("ws_en_last", mem_en, 1);
    mem_ready = 1'b1;
    mem_rdata = 8'h5A;
    tick();
    mem_ready = 1'b0;
    check_eq("ws_grant", grant_given, 4'b1000);
    check_eq("ws_data", data_to_core, 8'h5A);
    check_eq("ws_bus_error", bus_error, 0);
    tick();

    // Reset asserted mid-ACCESS
    grant_request = 4'b0010;
    tick();
    grant_request = 4'b0000;
    check_eq("mr_in_access", mem_en, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mr_mem_en", mem_en, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_grant", grant_given, 0);
    check_eq("mr_addr", mem_addr, 0);
    check_eq("mr_data", data_to_core, 0);
    tick(); tick();
    check_eq("mr_grant_hold", grant_given, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;

    // Round-robin with all cores requesting continuously
    grant_request = 4'b1111;
    mem_ready     = 1'b1;
    got_n    = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 30 && got_n < 5; cyc++) begin
      tick();
      if (grant_given != 0) begin
        check_eq($sformatf("rr_grant%0d", got_n), grant_given, EXP_RR[got_n]);
        if (got_n > 0) check_eq($sformatf("rr_spacing%0d", got_n), cyc - last_cyc, 3);
        last_cyc = cyc;
        got_n++;
      end
    end
    check_eq("rr_count", got_n, 5);
    grant_request = 4'b0000;
    mem_ready     = 1'b0;
    tick(); tick();
    check_eq("rr_idle", busy, 0);

    // Watchdog on the TIMEOUT=4 instance: mem_ready never asserted
    set_core(0, 1'b0, 10'h111, 8'h00);
    wd_request = 4'b0001;
    tick();
    wd_request = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("wd_wait_en%0d", k), wd_mem_en, 1);
      check_eq($sformatf("wd_wait_grant%0d", k), wd_grant_given, 0);
      tick();
    end
    check_eq("wd_wait_en3", wd_mem_en, 1);
    check_eq("wd_err_before", wd_bus_error, 0);
    tick();
    check_eq("wd_grant", wd_grant_given, 4'b0001);
    check_eq("wd_data", wd_data_to_core, 8'hFF);
    check_eq("wd_bus_error", wd_bus_error, 1);
    check_eq("wd_mem_en_off", wd_mem_en, 0);
    tick();
    check_eq("wd_grant_off", wd_grant_given, 0);

    // Good transaction afterwards: error stays sticky
    set_core(1, 1'b0, 10'h020, 8'h00);
    wd_request = 4'b0010;
    tick();
    wd_request = 4'b0000;
    mem_ready = 1'b1;
    mem_rdata = 8'h77;
    tick();
    mem_ready = 1'b0;
    check_eq("wd_good_grant", wd_grant_given, 4'b0010);
    check_eq("wd_good_data", wd_data_to_core, 8'h77);
    check_eq("wd_sticky", wd_bus_error, 1);
    tick();
    check_eq("wd_sticky_idle", wd_bus_error, 1);
    check_eq("main_no_error", bus_error, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single 8-bit-data, 10-bit-address memory bus between N_CORES core instances.
- Each core raises grant_request and waits for a one-cycle grant_given pulse. On that pulse, read data is valid and write data has been committed.
- Round-robin arbitration, one single-beat transaction at a time, and a watchdog that aborts stalled memory accesses.
- Sits between the core array and the memory/peripheral block.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- TIMEOUT, 16, ACCESS cycles allowed before abort; 0 disables the watchdog.
- OWNER_W, $clog2(N_CORES), width of the owner index (derived, not overridden).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- grant_request  in  N_CORES  per-core request, bit i from core i.
- rw  in  N_CORES  per-core direction, 1 = write, 0 = read.
- address  in  N_CORES*10  per-core address, core i at [10*i+9:10*i].
- data_from_core  in  N_CORES*8  per-core write data, core i at [8*i+7:8*i].
- grant_given  out  N_CORES  one-hot completion pulse to the owning core.
- data_to_core  out  8  read data broadcast to all cores, valid while grant_given is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  10  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data.
- mem_ready  in  1  memory completes the access in this cycle.
- owner  out  OWNER_W  index of the current or most recent bus owner.
- busy  out  1  high in ACCESS and DONE.
- bus_error  out  1  sticky; set on a watchdog abort.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; rr_ptr=N_CORES-1, so core 0 has top priority after reset; timeout counter=0.
- A reset asserted mid-transaction aborts it immediately, with no grant and no error.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any grant_request bit is high, pick the first set bit scanning from (rr_ptr+1) mod N_CORES upward with wrap.
  - At the edge: set owner and rr_ptr to the winner, and latch its address, rw and data_from_core into mem_addr, mem_we and mem_wdata.
  - Also at the edge: mem_en<=1, clear the counter, go to ACCESS.
  - With no request, stay in IDLE with mem_en=0.
- ACCESS:
  - mem_en, mem_addr, mem_we and mem_wdata are held stable.
  - On an edge with mem_ready=1: data_to_core<=mem_rdata for reads (unchanged for writes), grant_given[owner]<=1, mem_en<=0, mem_we<=0, go to DONE.
  - Otherwise the counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with mem_ready still low: data_to_core<=8'hFF, grant_given[owner]<=1, bus_error<=1, mem_en<=0, go to DONE.
  - mem_ready takes precedence over timeout in the same cycle.
- DONE: grant_given is high for exactly this one cycle. At the next edge grant_given<=0 and the state returns to IDLE.
  - The core drops its request on the edge where it sees the grant, so the finished request is never re-granted.
- Latency:
  - A request sampled at edge e0 with mem_ready high in the following cycle gives grant_given high after e1.
  - Minimum 3 cycles per transaction; back-to-back throughput is one transaction per 3 cycles.
- Request inputs are ignored outside IDLE.
  - A request that drops during ACCESS does not cancel the transaction.
  - Latched address and data are immune to input changes after the grant decision.
- grant_given is always zero or one-hot.
- mem_en=1 only in ACCESS.
- bus_error is cleared only by reset.
- mem_ready seen in IDLE or DONE is ignored.

Test Plan:
- Single read: core 1 requests a read of 10'h005, memory returns 8'h3C with mem_ready one cycle after mem_en -> mem_addr=10'h005, mem_we=0; grant_given=4'b0010 for one cycle with data_to_core=8'h3C; busy low two edges later.
- Single write: core 2 writes 8'hA5 to 10'h3FF -> mem_we=1, mem_wdata=8'hA5, mem_addr=10'h3FF held until mem_ready; grant_given=4'b0100 one-cycle pulse.
- Round-robin: all 4 cores request continuously, each re-raising its request the cycle after its grant -> grant order 0,1,2,3,0; no core is granted twice before the others; grant pulses spaced 3 cycles apart.
- Wait states: mem_ready held low 5 cycles -> mem_en and mem_addr stable all 5 cycles; grant pulses on the cycle after mem_ready; bus_error stays 0.
- Watchdog: TIMEOUT=4, mem_ready never asserted -> abort after 4 ACCESS cycles; data_to_core=8'hFF with a grant pulse; bus_error=1 and sticky across later good transactions.
- Reset mid-ACCESS: assert reset low asynchronously during ACCESS -> all outputs 0 immediately with no grant pulse; after release, core 0 wins if all cores request.
